divisor_secuencial: RTL and testbench

//   Sequential restoring divider, the inverse datapath of the N-bit shift-add multiplier.

---
 rtl/divisor_secuencial.sv | 90 +++++++++
 tb/tb_divisor_secuencial.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/divisor_secuencial.sv
// divisor_secuencial: restoring divider, 2N-bit dividend by N-bit divisor, one quotient bit per clock.
// Uses the same valid_data / Done_Flag / ack handshake as the shift-add multiplier.
module divisor_secuencial #(
   parameter int N = 32
) (
   input  logic           clk,
   input  logic           reset,
   input  logic [2*N-1:0] dividendo,
   input  logic [N-1:0]   divisor,
   input  logic           valid_data,
   input  logic           ack,
   output logic [2*N-1:0] cociente,
   output logic [N-1:0]   residuo,
   output logic           Done_Flag,
   output logic           div_cero,
   output logic           ocupado
);
   localparam int CW = $clog2(2*N) + 1;
   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] CALC   = 2'd1;
   localparam logic [1:0] DONE   = 2'd2;
   localparam logic [1:0] ESPERA = 2'd3;

   logic [1:0]     state;
   logic [N-1:0]   r, r_nx, d;
   logic [N:0]     r_sh;
   logic [2*N-1:0] q, q_nx;
   logic [CW-1:0]  cnt;
   logic           ge;

   // The partial remainder stays below the divisor, so N bits suffice between iterations.
   always_comb begin
      r_sh = {r, q[2*N-1]};
      ge   = r_sh >= {1'b0, d};
      r_nx = ge ? N'(r_sh - {1'b0, d}) : r_sh[N-1:0];
      q_nx = {q[2*N-2:0], ge};
   end

   assign ocupado = state != IDLE;

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         cociente  <= '0;
         residuo   <= '0;
         Done_Flag <= 1'b0;
         div_cero  <= 1'b0;
         cnt       <= '0;
         r         <= '0;
         q         <= '0;
         d         <= '0;
      end else begin
         case (state)
            IDLE: if (valid_data) begin
               d <= divisor;
               if (divisor == '0) begin
                  cociente  <= '1;
                  residuo   <= dividendo[N-1:0];
                  div_cero  <= 1'b1;
                  Done_Flag <= 1'b1;
                  state     <= DONE;
               end else begin
                  r     <= '0;
                  q     <= dividendo;
                  cnt   <= CW'(2*N);
                  state <= CALC;
               end
            end
            CALC: begin
               r   <= r_nx;
               q   <= q_nx;
               cnt <= cnt - 1'b1;
               if (cnt == CW'(1)) begin
                  cociente  <= q_nx;
                  residuo   <= r_nx;
                  Done_Flag <= 1'b1;
                  div_cero  <= 1'b0;
                  state     <= DONE;
               end
            end
            DONE: if (ack) begin
               Done_Flag <= 1'b0;
               div_cero  <= 1'b0;
               state     <= valid_data ? ESPERA : IDLE;
            end
            default: if (!valid_data) state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_divisor_secuencial.sv
// tb_divisor_secuencial: directed checks of the sequential divider with hand-computed results.
module tb_divisor_secuencial;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [63:0] dividendo = '0;
   logic [31:0] divisor = '0;
   logic        valid_data = 1'b0;
   logic        ack = 1'b0;
   logic [63:0] cociente;
   logic [31:0] residuo;
   logic        Done_Flag, div_cero, ocupado;
   int          errs = 0, checks = 0;

   always #5 clk = ~clk;

   divisor_secuencial #(.N(32)) dut (
      .clk(clk), .reset(reset), .dividendo(dividendo), .divisor(divisor),
      .valid_data(valid_data), .ack(ack), .cociente(cociente), .residuo(residuo),
      .Done_Flag(Done_Flag), .div_cero(div_cero), .ocupado(ocupado)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic start(input logic [63:0] dd, input logic [31:0] dv, input bit hold);
      @(negedge clk);
      dividendo  = dd;
      divisor    = dv;
      valid_data = 1'b1;
      @(posedge clk);
      #1;
      if (!hold) valid_data = 1'b0;
      dividendo = ~dd;
      divisor   = ~dv;
   endtask

   task automatic wait_done(output int cyc);
      cyc = 0;
      while (!Done_Flag && cyc < 200) begin
         @(posedge clk);
         #1;
         cyc++;
      end
   endtask

   task automatic do_ack();
      @(negedge clk);
      ack = 1'b1;
      @(posedge clk);
      #1;
      ack = 1'b0;
   endtask

   task automatic run(input string tag, input logic [63:0] dd, input logic [31:0] dv,
                      input logic [63:0] eq, input logic [31:0] er);
      int c;
      start(dd, dv, 1'b0);
      chk({tag, "_busy"}, 64'(ocupado), 64'd1);
      wait_done(c);
      chk({tag, "_lat"}, 64'(c), 64'd64);
      chk({tag, "_q"}, cociente, eq);
      chk({tag, "_r"}, 64'(residuo), 64'(er));
      chk({tag, "_dz"}, 64'(div_cero), 64'd0);
      do_ack();
      chk({tag, "_ackdone"}, 64'(Done_Flag), 64'd0);
      chk({tag, "_idle"}, 64'(ocupado), 64'd0);
   endtask

   initial begin
      int c, bad;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_q", cociente, 64'd0);
      chk("rst_r", 64'(residuo), 64'd0);
      chk("rst_flags", {61'd0, Done_Flag, div_cero, ocupado}, 64'd0);
      reset = 1'b0;

      run("t1", 64'd96, 32'd3, 64'd32, 32'd0);

      start(64'd100, 32'd7, 1'b0);
      wait_done(c);
      chk("t2_lat", 64'(c), 64'd64);
      bad = 0;
      repeat (10) begin
         @(posedge clk);
         #1;
         if (!Done_Flag || cociente !== 64'd14 || residuo !== 32'd2) bad++;
      end
      chk("t2_stable", 64'(bad), 64'd0);
      chk("t2_q", cociente, 64'd14);
      chk("t2_r", 64'(residuo), 64'd2);
      do_ack();
      chk("t2_ackdone", 64'(Done_Flag), 64'd0);

      run("t3a", 64'hFFFF_FFFF_FFFF_FFFF, 32'd1, 64'hFFFF_FFFF_FFFF_FFFF, 32'd0);
      run("t3b", 64'hFFFF_FFFF_FFFF_FFFF, 32'hFFFF_FFFF, 64'h1_0000_0001, 32'd0);
      run("t3c", 64'hDEAD_BEEF_0000_0007, 32'h10, 64'h0DEA_DBEE_F000_0000, 32'd7);

      start(64'h1234_5678_9ABC_DEF0, 32'd0, 1'b0);
      @(posedge clk);
      #1;
      chk("t4_done", 64'(Done_Flag), 64'd1);
      chk("t4_dz", 64'(div_cero), 64'd1);
      chk("t4_q", cociente, 64'hFFFF_FFFF_FFFF_FFFF);
      chk("t4_r", 64'(residuo), 64'h9ABC_DEF0);
      do_ack();
      chk("t4_ack", 64'({Done_Flag, div_cero}), 64'd0);

      start(64'd100, 32'd7, 1'b1);
      wait_done(c);
      chk("t5_q1", cociente, 64'd14);
      do_ack();
      chk("t5_espera", 64'({Done_Flag, ocupado}), 64'd1);
      bad = 0;
      repeat (70) begin
         @(posedge clk);
         #1;
         if (Done_Flag) bad++;
      end
      chk("t5_nodone", 64'(bad), 64'd0);
      chk("t5_held", 64'(ocupado), 64'd1);
      @(negedge clk);
      valid_data = 1'b0;
      @(posedge clk);
      #1;
      chk("t5_idle", 64'(ocupado), 64'd0);
      run("t5b", 64'd25, 32'd5, 64'd5, 32'd0);

      start(64'd96, 32'd3, 1'b0);
      repeat (19) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      chk("t6_rst_q", cociente, 64'd0);
      chk("t6_rst_r", 64'(residuo), 64'd0);
      chk("t6_rst_flags", {61'd0, Done_Flag, div_cero, ocupado}, 64'd0);
      reset = 1'b0;
      run("t6", 64'd96, 32'd3, 64'd32, 32'd0);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
